// File: rtl/simd_shift_issue.sv
// rtl/simd_shift_issue.sv - request FIFO and registered result slot around the SIMD shifter
package simd_shift_pkg;
  typedef logic [63:0] word_t;
  typedef logic [5:0]  shift_t;
  typedef enum logic [1:0] {
    MODE_64   = 2'd0,
    MODE_32   = 2'd1,
    MODE_16   = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;
  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SLA = 2'd1,
    OP_SRL = 2'd2,
    OP_SRA = 2'd3
  } op_t;
endpackage

module simd_shift_issue
  import simd_shift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  word_t        in_word,
  input  mode_t        in_mode,
  input  op_t          in_op,
  input  shift_t [3:0] in_shift,
  output logic         in_rdy,
  output word_t        sh_in,
  output mode_t        sh_mode,
  output op_t          sh_op,
  output shift_t [3:0] sh_shift,
  input  word_t        sh_out,
  output logic         out_vld,
  output word_t        out_word,
  input  logic         out_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  word_t        word_mem  [DEPTH];
  mode_t        mode_mem  [DEPTH];
  op_t          op_mem    [DEPTH];
  shift_t [3:0] shift_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          not_empty;
  logic          push;
  logic          pop;

  // in_rdy looks only at registered count so out_rdy never reaches it combinationally
  assign not_empty = (count != '0);
  assign in_rdy    = (count != FULL);
  assign push      = in_vld & in_rdy;
  assign pop       = not_empty & (~out_vld | out_rdy);

  // Present the FIFO head to the shifter; drive zeros when nothing is queued
  always_comb begin
    sh_in    = '0;
    sh_mode  = MODE_64;
    sh_op    = OP_SLL;
    sh_shift = '0;
    if (not_empty) begin
      sh_in    = word_mem[rd_ptr];
      sh_mode  = mode_mem[rd_ptr];
      sh_op    = op_mem[rd_ptr];
      sh_shift = shift_mem[rd_ptr];
    end
  end

  // Request storage; contents are don't-care until pointed at, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr]  <= in_word;
      mode_mem[wr_ptr]  <= in_mode;
      op_mem[wr_ptr]    <= in_op;
      shift_mem[wr_ptr] <= in_shift;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Output slot captures the shifter result on every pop and holds it while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_word <= '0;
    end else if (pop) begin
      out_vld  <= 1'b1;
      out_word <= sh_out;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simd_shift_issue.sv
// tb/tb_simd_shift_issue.sv - directed self-checking bench for simd_shift_issue
module tb_simd_shift_issue;
  import simd_shift_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         in_vld;
  word_t        in_word;
  mode_t        in_mode;
  op_t          in_op;
  shift_t [3:0] in_shift;
  logic         in_rdy;
  word_t        sh_in;
  mode_t        sh_mode;
  op_t          sh_op;
  shift_t [3:0] sh_shift;
  word_t        sh_out;
  logic         out_vld;
  word_t        out_word;
  logic         out_rdy;

  int n_cmp = 0;
  int n_bad = 0;
  word_t exp_q [$];
  int acc;
  int nw;

  simd_shift_issue #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_word  (in_word),
    .in_mode  (in_mode),
    .in_op    (in_op),
    .in_shift (in_shift),
    .in_rdy   (in_rdy),
    .sh_in    (sh_in),
    .sh_mode  (sh_mode),
    .sh_op    (sh_op),
    .sh_shift (sh_shift),
    .sh_out   (sh_out),
    .out_vld  (out_vld),
    .out_word (out_word),
    .out_rdy  (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference SIMD shifter standing in for the downstream combinational block
  function automatic word_t shifter(input word_t w, input mode_t m, input op_t op, input shift_t [3:0] s);
    word_t r;
    int lanes;
    int lw;
    int amt;
    int src;
    r = '0;
    lanes = (m == MODE_32) ? 2 : (m == MODE_16) ? 4 : 1;
    lw = 64 / lanes;
    for (int l = 0; l < lanes; l++) begin
      amt = int'(s[l]) % lw;
      for (int b = 0; b < lw; b++) begin
        if (op == OP_SLL || op == OP_SLA) begin
          src = b - amt;
          r[l*lw+b] = (src >= 0) ? w[l*lw+src] : 1'b0;
        end else begin
          src = b + amt;
          if (src < lw) r[l*lw+b] = w[l*lw+src];
          else          r[l*lw+b] = (op == OP_SRA) ? w[l*lw+lw-1] : 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb sh_out = shifter(sh_in, sh_mode, sh_op, sh_shift);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input word_t w, input op_t op, input shift_t s0, input word_t exp);
    in_vld = 1'b1; in_word = w; in_op = op; in_mode = MODE_64;
    in_shift = '0; in_shift[0] = s0; out_rdy = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, in_rdy, 1);
    nxt();
    in_vld = 1'b0;
    @(negedge clk);
    chk({tag, "_c1_vld"}, out_vld, 0);
    chk({tag, "_c1_head"}, sh_in, w);
    nxt();
    @(negedge clk);
    chk({tag, "_c2_vld"}, out_vld, 1);
    chk({tag, "_c2_word"}, out_word, exp);
    nxt();
    @(negedge clk);
    chk({tag, "_c3_vld"}, out_vld, 0);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_word = '0; in_mode = MODE_64;
    in_op = OP_SLL; in_shift = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_sh_in", sh_in, 0);
    chk("rst_sh_shift", sh_shift, 0);
    nxt();

    // single request latency and sign propagation
    single("sll", 64'h1, OP_SLL, 6'd4, 64'h10);
    single("sra", 64'h8000_0000_0000_0000, OP_SRA, 6'd8, 64'hFF80_0000_0000_0000);
    single("srl", 64'h8000_0000_0000_0000, OP_SRL, 6'd8, 64'h0080_0000_0000_0000);

    // fill with output stalled: FIFO plus output slot hold five
    out_rdy = 1'b0; in_shift = '0; in_op = OP_SLL; nw = 1; acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_vld = 1'b1; in_word = word_t'(nw);
      @(negedge clk);
      if (c >= 5) chk("fill_rdy_low", in_rdy, 0);
      if (c >= 2) begin
        chk("fill_vld", out_vld, 1);
        chk("fill_hold", out_word, 1);
      end
      if (in_rdy) begin acc++; nw++; end
      nxt();
    end
    chk("fill_accepts", acc, 5);

    // release: results 1..7 back to back, 6 and 7 enter as space frees
    out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_vld = (nw <= 7); in_word = word_t'(nw);
      @(negedge clk);
      if (c < 7) begin
        chk("drain_vld", out_vld, 1);
        chk("drain_word", out_word, c + 1);
      end else begin
        chk("drain_end_vld", out_vld, 0);
      end
      if (in_vld && in_rdy) begin acc++; nw++; end
      nxt();
    end
    chk("drain_accepts", acc, 7);
    in_vld = 1'b0;

    // streaming with pointer wrap
    acc = 0; in_shift[0] = 6'd1;
    for (int t = 0; t < 22; t++) begin
      in_vld = (acc < 20); in_word = word_t'(acc);
      @(negedge clk);
      if (t >= 2) begin
        chk("stream_vld", out_vld, 1);
        chk("stream_word", out_word, 2 * (t - 2));
      end
      chk("stream_count", dut.count <= 1, 1);
      if (in_vld && in_rdy) acc++;
      nxt();
    end
    chk("stream_accepts", acc, 20);
    in_vld = 1'b0; in_shift = '0;
    nxt();

    // build count = 2 with the output stalled, then push/pop together under random stalls
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_vld = 1'b1; in_word = word_t'(100 + k);
      @(negedge clk);
      if (in_rdy) exp_q.push_back(in_word);
      nxt();
    end
    for (int k = 0; k < 30; k++) begin
      out_rdy = 1'($urandom_range(0, 1));
      in_vld = out_rdy; in_word = word_t'(200 + k);
      @(negedge clk);
      chk("pp_count", dut.count, 2);
      if (out_vld && out_rdy) chk("pp_data", out_word, exp_q.pop_front());
      else if (out_vld) chk("pp_hold", out_word, exp_q[0]);
      if (in_vld && in_rdy) exp_q.push_back(in_word);
      nxt();
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_vld) chk("pp_drain", out_word, exp_q.pop_front());
      nxt();
    end
    chk("pp_empty", exp_q.size(), 0);

    // reset mid-stream with count = 3 and a stalled result
    out_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_vld = 1'b1; in_word = word_t'(50 + k);
      nxt();
    end
    rst_n = 1'b0; in_word = 64'd99;
    @(negedge clk);
    chk("pre_rst_count", dut.count, 3);
    chk("pre_rst_vld", out_vld, 1);
    nxt();
    rst_n = 1'b1; in_vld = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_word", out_word, 0);
    chk("mid_rst_rdy", in_rdy, 1);
    chk("mid_rst_sh_in", sh_in, 0);
    chk("mid_rst_sh_op", sh_op, 0);
    chk("mid_rst_sh_mode", sh_mode, 0);
    chk("mid_rst_sh_shift", sh_shift, 0);
    nxt();
    single("post_rst", 64'h3, OP_SLL, 6'd2, 64'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simd_shift_issue.md
# simd_shift_issue

Request-buffering issue stage that sits directly upstream of the combinational SIMD shifter. It accepts shift requests (word, mode, op, per-lane shift amounts) over a valid/ready handshake and holds them in a DEPTH-entry FIFO. It presents the FIFO head to the shifter's inputs, then captures the shifter's 64-bit result in a registered output slot with its own valid/ready handshake. This gives the shifter a registered, back-pressurable front/back end at one result per cycle.

## Interface
- DEPTH, 4, request FIFO depth; power of two, >= 2.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_vld  in  1  request valid.
- in_word  in  64 (word_t)  operand.
- in_mode  in  mode_t  SIMD lane mode, carried through unmodified.
- in_op  in  op_t  SLL/SLA/SRL/SRA, carried through unmodified.
- in_shift  in  shift_t [3:0]  per-lane shift amounts.
- in_rdy  out  1  request accepted when in_vld & in_rdy.
- sh_in, sh_mode, sh_op, sh_shift  out  word_t/mode_t/op_t/shift_t[3:0]  drive the shifter inputs.
- sh_out  in  64 (word_t)  shifter result; combinational function of sh_*.
- out_vld  out  1  result valid.
- out_word  out  64  result.
- out_rdy  in  1  result consumed when out_vld & out_rdy.

## Operation
- FIFO state: wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- in_rdy = (count != DEPTH). It is a function of registered count only. A pop in the same cycle does not raise in_rdy when full.
- push = in_vld & in_rdy. Writes {word, mode, op, shift} at wr_ptr and increments wr_ptr.
- sh_* = FIFO head fields when count != 0. When count == 0, all sh_* are driven to zero.
- pop = (count != 0) & (!out_vld | out_rdy). On pop:
  - out_word <= sh_out
  - out_vld <= 1
  - rd_ptr increments
- If there is no pop and out_vld & out_rdy, then out_vld <= 0. out_word holds its value.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any count except full; when full, push is blocked by in_rdy.
- Total buffering is DEPTH + 1 (the FIFO plus the output slot).
- Field values and op encodings are passed through verbatim; no checking is performed.
- Reset (rst_n low at an edge):
  - count = 0, wr_ptr = 0, rd_ptr = 0
  - out_vld = 0, out_word = 0
  - FIFO storage is not reset
- Any push or pop in a reset cycle is discarded. This applies mid-operation too: in-flight requests are lost.
- Reset output values:
  - in_rdy = 1 in the first cycle after reset
  - sh_* = 0
  - out_vld = 0
  - out_word = 0

## Timing
- Latency:
  - A request accepted at the edge ending cycle 0 is at the FIFO head in cycle 1 (if the FIFO was empty).
  - It is captured at the end of cycle 1.
  - out_vld = 1 with its result in cycle 2.
- No combinational path from in_* to out_*, or from out_rdy to in_rdy.
- sh_out to out_word is a single register stage.
- Throughput: one request per cycle sustained with out_rdy held high.
- Backpressure:
  - out_rdy low holds out_vld/out_word stable.
  - After DEPTH further accepts, in_rdy drops on the cycle following the DEPTH-th push.
- out_vld, once asserted, stays high with stable out_word until out_rdy is sampled high.
- The FIFO drains in order; results leave in acceptance order.

## Test plan
- Single request, out_rdy = 1:
  - Stimulus: in_word = 0x1, op = SLL, shift[0] = 4, accepted cycle 0.
  - Required: out_vld = 1 in cycle 2 with out_word = 0x10; out_vld = 0 in cycle 3.
- Sign propagation:
  - Stimulus: in_word = 0x8000_0000_0000_0000, op = SRA, shift[0] = 8.
  - Required: out_word = 0xFF80_0000_0000_0000.
  - With op = SRL, same inputs: out_word = 0x0080_0000_0000_0000.
- Fill/backpressure (DEPTH = 4):
  - Stimulus: out_rdy = 0; in_vld high with words 1..7, op = SLL, shift 0.
  - Required: exactly 5 accepts; in_rdy = 0 from the cycle after the 5th accept; out_word = 1 held stable.
  - Then raise out_rdy: outputs 1, 2, 3, 4, 5 appear on consecutive cycles; words 6 and 7 are accepted as space frees.
- Streaming with pointer wrap:
  - Stimulus: 20 back-to-back requests, in_word = i, op = SLL, shift[0] = 1, out_rdy = 1.
  - Required: outputs 2*i in order, one per cycle, no bubbles after the first; count never exceeds 1.
- Random out_rdy stall with simultaneous push/pop at count = 2:
  - Required: count stays 2; no loss or duplication against a reference model.
- Reset mid-stream:
  - Stimulus: rst_n = 0 for 1 cycle while count = 3 and out_vld = 1.
  - Required: next cycle out_vld = 0, out_word = 0, in_rdy = 1, sh_* = 0; a post-reset request completes with 2-cycle latency.
